// File: rtl/arbitro_leituras_rr.sv
// Round-robin read arbiter: grants one requester at a time, drives every memory read port with its addresses, and returns the captured data.
// Optional per-requester grant counters are enabled by defining ARB_LEITURAS_PERF_EN.
module arbitro_leituras_rr #(
    parameter int NUM_READ_PORTS   = 8,
    parameter int NUM_SOLICITACOES = 8,
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 8,
    parameter int MEM_LATENCY      = 2,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [NUM_SOLICITACOES-1:0]                         req_in,
    input  logic [ADDR_WIDTH*NUM_READ_PORTS*NUM_SOLICITACOES-1:0] req_addr_in,
    output logic [NUM_SOLICITACOES-1:0]                         ready_out,
    output logic [DATA_WIDTH*NUM_READ_PORTS-1:0]                read_data_out,
    output logic                                                busy_out,
    output logic                                                read_en_out,
    output logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]                read_addr_out,
    input  logic [DATA_WIDTH*NUM_READ_PORTS-1:0]                mem_read_data_in
`ifdef ARB_LEITURAS_PERF_EN
    ,
    output logic [CNT_WIDTH*NUM_SOLICITACOES-1:0]               grant_cnt_out
`endif
);

    localparam int SLICE_W = ADDR_WIDTH * NUM_READ_PORTS;
    localparam int GW      = $clog2(NUM_SOLICITACOES);
    localparam int CW      = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAT      = CW'(MEM_LATENCY);
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_SOLICITACOES - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESPERA  = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    estado_t        state;
    logic [GW-1:0]  ptr;
    logic [GW-1:0]  grant_id;
    logic [CW-1:0]  cnt;
    logic [GW-1:0]  sel_idx;
    logic [GW-1:0]  cand_idx;
    logic           sel_valid;
    logic [SLICE_W-1:0] req_addr_arr [NUM_SOLICITACOES];

    for (genvar k = 0; k < NUM_SOLICITACOES; k++) begin : g_slice
        assign req_addr_arr[k] = req_addr_in[k*SLICE_W +: SLICE_W];
    end

    // Scan from the farthest offset down to ptr itself, so the nearest set request wins.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and gives every output a default first, so no latch is inferred.
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int i = NUM_SOLICITACOES - 1; i >= 0; i--) begin
            cand_idx = GW'((int'(ptr) + i) % NUM_SOLICITACOES);
            if (req_in[cand_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
        if (rst) begin
            state         <= OCIOSO;
            ptr           <= '0;
            grant_id      <= '0;
            cnt           <= '0;
            ready_out     <= '0;
            read_data_out <= '0;
            busy_out      <= 1'b0;
            read_en_out   <= 1'b0;
            read_addr_out <= '0;
        end else begin
            read_en_out <= 1'b0;
            ready_out   <= '0;
            case (state)
                OCIOSO: begin
                    if (sel_valid) begin
                        read_addr_out <= req_addr_arr[sel_idx];
                        grant_id      <= sel_idx;
                        cnt           <= LAT;
                        ptr           <= (sel_idx == LAST_IDX) ? '0 : sel_idx + GW'(1);
                        read_en_out   <= 1'b1;
                        busy_out      <= 1'b1;
                        state         <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (cnt == '0) begin
                        read_data_out <= mem_read_data_in;
                        ready_out     <= {{(NUM_SOLICITACOES-1){1'b0}}, 1'b1} << grant_id;
                        state         <= ENTREGA;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ENTREGA: begin
                    busy_out <= 1'b0;
                    state    <= OCIOSO;
                end
                default: state <= OCIOSO;
            endcase
        end
    end

`ifdef ARB_LEITURAS_PERF_EN
    logic [CNT_WIDTH-1:0] grant_cnt [NUM_SOLICITACOES];

    always_ff @(posedge clk) begin
        // NOTE: this small counter array must read zero after reset, so it is cleared element by element; large storage arrays normally are not reset.
        if (rst) begin
            for (int k = 0; k < NUM_SOLICITACOES; k++) grant_cnt[k] <= '0;
        end else if (state == OCIOSO && sel_valid && grant_cnt[sel_idx] != '1) begin
            grant_cnt[sel_idx] <= grant_cnt[sel_idx] + CNT_WIDTH'(1);
        end
    end

    for (genvar k = 0; k < NUM_SOLICITACOES; k++) begin : g_cnt
        assign grant_cnt_out[k*CNT_WIDTH +: CNT_WIDTH] = grant_cnt[k];
    end
`endif

endmodule

// File: tb/tb_arbitro_leituras_rr.sv
// Scoreboard bench for arbitro_leituras_rr: directed request patterns push expected ready/data/cycle, a monitor pops on each ready pulse.
// Define ARB_LEITURAS_PERF_EN to also exercise the saturating grant counters.
module tb_arbitro_leituras_rr;

    localparam int N   = 8;
    localparam int P   = 8;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam int CW  = 2;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req_in;
    logic [AW*P*N-1:0]    req_addr_in;
    logic [N-1:0]         ready_out;
    logic [DW*P-1:0]      read_data_out;
    logic                 busy_out;
    logic                 read_en_out;
    logic [AW*P-1:0]      read_addr_out;
    logic [DW*P-1:0]      mem_read_data_in;
`ifdef ARB_LEITURAS_PERF_EN
    logic [CW*N-1:0]      grant_cnt_out;
`endif

    arbitro_leituras_rr #(
        .NUM_READ_PORTS(P), .NUM_SOLICITACOES(N), .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .req_addr_in(req_addr_in),
        .ready_out(ready_out), .read_data_out(read_data_out), .busy_out(busy_out),
        .read_en_out(read_en_out), .read_addr_out(read_addr_out),
        .mem_read_data_in(mem_read_data_in)
`ifdef ARB_LEITURAS_PERF_EN
        , .grant_cnt_out(grant_cnt_out)
`endif
    );

    typedef struct {
        logic [N-1:0]    ready;
        logic [DW*P-1:0] data;
        int              due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   c0;
    logic [DW*P-1:0] d1, d2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [AW*P-1:0] mk_addr(logic [7:0] base, logic [7:0] stride);
        logic [AW*P-1:0] r;
        for (int p = 0; p < P; p++) r[p*AW +: AW] = base + 8'(p) * stride;
        return r;
    endfunction

    // Memory model: each port returns a pattern derived from its address, LAT cycles later.
    function automatic logic [DW*P-1:0] mem_f(logic [AW*P-1:0] a);
        logic [DW*P-1:0] r;
        logic [7:0] ap;
        for (int p = 0; p < P; p++) begin
            ap = a[p*AW +: AW];
            r[p*DW +: DW] = {~ap, ap ^ 8'h5A, 8'(p), ap};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        d1 <= mem_f(read_addr_out);
        d2 <= d1;
    end
    assign mem_read_data_in = d2;

    task automatic check(string name, logic [DW*P-1:0] act, logic [DW*P-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (ready_out !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", ready_out, '0);
            end else begin
                mon_e = sb.pop_front();
                check("ready_id", ready_out, mon_e.ready);
                check("ready_data", read_data_out, mon_e.data);
                check("ready_cycle", cyc, mon_e.due);
            end
        end
    end

    // Advance one cycle; a requester drops its request the cycle after its ready pulse.
    task automatic tick();
        logic [N-1:0] served;
        served = ready_out;
        @(posedge clk);
        #1;
        req_in = req_in & ~served;
    endtask

    task automatic expect_rdy(int k, int due);
        exp_t e;
        e.ready = N'(1) << k;
        e.data  = mem_f(req_addr_in[k*AW*P +: AW*P]);
        e.due   = due;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((sb.size() != 0 || busy_out) && n < 100);
        if (sb.size() != 0 || busy_out) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d busy %0b, expected 0 and 0", sb.size(), busy_out);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_quiet(string tag);
        check({tag, "_ready"}, ready_out, '0);
        check({tag, "_busy"}, busy_out, 1'b0);
        check({tag, "_read_en"}, read_en_out, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_in = '0;
        req_addr_in = '0;
        for (int k = 0; k < N; k++) req_addr_in[k*AW*P +: AW*P] = mk_addr(8'(16*k + 1), 8'h11);
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check_quiet("reset");
        check("reset_addr", read_addr_out, '0);
        check("reset_data", read_data_out, '0);

        // No request: remains idle
        repeat (3) tick();
        check_quiet("idle");

        // Single request from requester 3 with A5 on every port
        req_addr_in[3*AW*P +: AW*P] = mk_addr(8'hA5, 8'h00);
        c0 = cyc;
        req_in = 8'h08;
        expect_rdy(3, c0 + 4);
        tick();
        check("t1_read_en_c1", read_en_out, 1'b1);
        check("t1_addr_c1", read_addr_out, {8{8'hA5}});
        check("t1_busy_c1", busy_out, 1'b1);
        tick();
        check("t1_read_en_c2", read_en_out, 1'b0);
        wait_done();
        check("t1_data_hold", read_data_out, mem_f({8{8'hA5}}));
        check("t1_addr_hold", read_addr_out, {8{8'hA5}});

        // All requests from ptr=0: order 0..7, pulses 5 cycles apart
        do_reset();
        c0 = cyc;
        req_in = 8'hFF;
        for (int k = 0; k < N; k++) expect_rdy(k, c0 + 4 + 5*k);
        wait_done();
        check("t2_addr_hold", read_addr_out, req_addr_in[7*AW*P +: AW*P]);

        // Fairness: after serving 6, 7 beats 2
        c0 = cyc;
        req_in = 8'h40;
        expect_rdy(6, c0 + 4);
        wait_done();
        c0 = cyc;
        req_in = 8'h84;
        expect_rdy(7, c0 + 4);
        expect_rdy(2, c0 + 9);
        wait_done();

        // Fairness: after serving 7, 0 beats 7
        c0 = cyc;
        req_in = 8'h80;
        expect_rdy(7, c0 + 4);
        wait_done();
        c0 = cyc;
        req_in = 8'h81;
        expect_rdy(0, c0 + 4);
        expect_rdy(7, c0 + 9);
        wait_done();

        // Reset during ESPERA with request 4 held: only the re-grant completes
        c0 = cyc;
        req_in = 8'h10;
        expect_rdy(4, c0 + 7);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_quiet("t4_rst");
        check("t4_rst_addr", read_addr_out, '0);
        check("t4_rst_data", read_data_out, '0);
        rst = 1'b0;
        wait_done();

        // Early drop of request 1 in the second ESPERA cycle
        c0 = cyc;
        req_in = 8'h02;
        expect_rdy(1, c0 + 4);
        tick();
        tick();
        req_in = 8'h00;
        wait_done();
        tick();
        check_quiet("t5_after");

`ifdef ARB_LEITURAS_PERF_EN
        // Five grants to requester 0 saturate a 2-bit counter
        do_reset();
        for (int g = 0; g < 5; g++) begin
            c0 = cyc;
            req_in = 8'h01;
            expect_rdy(0, c0 + 4);
            wait_done();
        end
        check("t6_grant_cnt", grant_cnt_out, {14'h0, 2'd3});
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
